// File: rtl/ir_sweep_sched.sv
`default_nettype none
// ============================================================================
// Module      : ir_sweep_sched
// Description : Sequences the inner/middle/outer IR emitter pairs through the
//               shared A2D and publishes a weighted right-minus-left error.
// Revision    : 1.0 - initial release
// ============================================================================
module ir_sweep_sched #(
    parameter int         SETTLE_CYC = 4096,
    parameter logic [2:0] CH_IN_R    = 3'd1,
    parameter logic [2:0] CH_IN_L    = 3'd0,
    parameter logic [2:0] CH_MID_R   = 3'd4,
    parameter logic [2:0] CH_MID_L   = 3'd2,
    parameter logic [2:0] CH_OUT_R   = 3'd3,
    parameter logic [2:0] CH_OUT_L   = 3'd7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    output logic               strt_cnv,
    output logic [2:0]         chnnl,
    input  logic               cnv_cmplt,
    input  logic [11:0]        res,
    output logic               IR_in_en,
    output logic               IR_mid_en,
    output logic               IR_out_en,
    output logic signed [15:0] error,
    output logic               err_vld,
    output logic               busy
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_SETTLE = 3'd1;
    localparam logic [2:0] c_CNV_R  = 3'd2;
    localparam logic [2:0] c_WAIT_R = 3'd3;
    localparam logic [2:0] c_CNV_L  = 3'd4;
    localparam logic [2:0] c_WAIT_L = 3'd5;
    localparam logic [2:0] c_NEXT   = 3'd6;
    localparam logic [2:0] c_DONE   = 3'd7;

    localparam logic [15:0] c_SETTLE_LAST = 16'(SETTLE_CYC - 1);

    logic [2:0]         r_state;
    logic [15:0]        r_cnt;
    logic [1:0]         r_pair;
    logic signed [15:0] r_acc;
    logic               r_strt_cnv;
    logic [2:0]         r_chnnl;
    logic               r_ir_in;
    logic               r_ir_mid;
    logic               r_ir_out;
    logic signed [15:0] r_error;
    logic               r_err_vld;
    logic               r_busy;

    logic [15:0]        w_term;
    logic [2:0]         w_ch_r;
    logic [2:0]         w_ch_l;
    logic               w_settle_done;

    // Pair weight 1/2/4 is a left shift by the pair index.
    always_comb begin
        w_term = {4'b0000, res} << r_pair;
        w_ch_r = CH_IN_R;
        w_ch_l = CH_IN_L;
        case (r_pair)
            2'd1: begin
                w_ch_r = CH_MID_R;
                w_ch_l = CH_MID_L;
            end
            2'd2: begin
                w_ch_r = CH_OUT_R;
                w_ch_l = CH_OUT_L;
            end
            default: begin
                w_ch_r = CH_IN_R;
                w_ch_l = CH_IN_L;
            end
        endcase
    end

    assign w_settle_done = (r_cnt == c_SETTLE_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= c_IDLE;
            r_cnt      <= 16'd0;
            r_pair     <= 2'd0;
            r_acc      <= 16'sd0;
            r_strt_cnv <= 1'b0;
            r_chnnl    <= 3'd0;
            r_ir_in    <= 1'b0;
            r_ir_mid   <= 1'b0;
            r_ir_out   <= 1'b0;
            r_error    <= 16'sd0;
            r_err_vld  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_strt_cnv <= 1'b0;
            r_err_vld  <= 1'b0;
            case (r_state)
                // DONE shares IDLE's start logic so back-to-back sweeps lose no cycle.
                c_IDLE, c_DONE: begin
                    if (en) begin
                        r_acc   <= 16'sd0;
                        r_pair  <= 2'd0;
                        r_ir_in <= 1'b1;
                        r_cnt   <= 16'd0;
                        r_busy  <= 1'b1;
                        r_state <= c_SETTLE;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= c_IDLE;
                    end
                end
                c_SETTLE: begin
                    r_cnt <= r_cnt + 16'd1;
                    if (w_settle_done) begin
                        r_strt_cnv <= 1'b1;
                        r_chnnl    <= w_ch_r;
                        r_state    <= c_CNV_R;
                    end
                end
                c_CNV_R: begin
                    r_state <= c_WAIT_R;
                end
                c_WAIT_R: begin
                    if (cnv_cmplt) begin
                        r_acc      <= r_acc + signed'(w_term);
                        r_strt_cnv <= 1'b1;
                        r_chnnl    <= w_ch_l;
                        r_state    <= c_CNV_L;
                    end
                end
                c_CNV_L: begin
                    r_state <= c_WAIT_L;
                end
                c_WAIT_L: begin
                    if (cnv_cmplt) begin
                        r_acc   <= r_acc - signed'(w_term);
                        r_state <= c_NEXT;
                    end
                end
                c_NEXT: begin
                    case (r_pair)
                        2'd0: begin
                            r_ir_in  <= 1'b0;
                            r_ir_mid <= 1'b1;
                            r_pair   <= 2'd1;
                            r_cnt    <= 16'd0;
                            r_state  <= c_SETTLE;
                        end
                        2'd1: begin
                            r_ir_mid <= 1'b0;
                            r_ir_out <= 1'b1;
                            r_pair   <= 2'd2;
                            r_cnt    <= 16'd0;
                            r_state  <= c_SETTLE;
                        end
                        default: begin
                            r_ir_out  <= 1'b0;
                            r_error   <= r_acc;
                            r_err_vld <= 1'b1;
                            r_state   <= c_DONE;
                        end
                    endcase
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign strt_cnv  = r_strt_cnv;
    assign chnnl     = r_chnnl;
    assign IR_in_en  = r_ir_in;
    assign IR_mid_en = r_ir_mid;
    assign IR_out_en = r_ir_out;
    assign error     = r_error;
    assign err_vld   = r_err_vld;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_ir_sweep_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_ir_sweep_sched
// Description : Directed bench for ir_sweep_sched with a delayed A2D responder.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ir_sweep_sched;

    localparam int c_SETTLE = 8;
    localparam int c_LAT    = 20;
    localparam int c_BOUND  = 3000;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               en;
    logic               strt_cnv;
    logic [2:0]         chnnl;
    logic               cnv_cmplt;
    logic [11:0]        res;
    logic               IR_in_en;
    logic               IR_mid_en;
    logic               IR_out_en;
    logic signed [15:0] error;
    logic               err_vld;
    logic               busy;

    ir_sweep_sched #(.SETTLE_CYC(c_SETTLE)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .strt_cnv  (strt_cnv),
        .chnnl     (chnnl),
        .cnv_cmplt (cnv_cmplt),
        .res       (res),
        .IR_in_en  (IR_in_en),
        .IR_mid_en (IR_mid_en),
        .IR_out_en (IR_out_en),
        .error     (error),
        .err_vld   (err_vld),
        .busy      (busy)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [11:0]        r_in;
        logic [11:0]        l_in;
        logic [11:0]        r_mid;
        logic [11:0]        l_mid;
        logic [11:0]        r_out;
        logic [11:0]        l_out;
        logic signed [15:0] exp_err;
    } vec_t;

    int errors = 0;
    int checks = 0;

    // A2D model: answers each strt_cnv c_LAT cycles later with the table entry.
    logic [11:0] res_tab [8];
    logic [2:0]  ch_log [$];
    int          resp_cnt = 0;
    logic [2:0]  resp_ch  = 3'd0;
    initial begin
        cnv_cmplt = 1'b0;
        res       = 12'd0;
        forever begin
            @(negedge clk);
            cnv_cmplt = 1'b0;
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    cnv_cmplt = 1'b1;
                    res       = res_tab[resp_ch];
                end
            end else if (strt_cnv) begin
                resp_cnt = c_LAT;
                resp_ch  = chnnl;
                ch_log.push_back(chnnl);
            end
        end
    end

    // Monitor: err_vld pulses, emitter exclusivity/handoff, settle gap.
    int                 vld_cnt = 0;
    logic signed [15:0] last_err = 16'sd0;
    int                 onehot_viol = 0;
    int                 handoff_viol = 0;
    int                 gaps [$];
    int                 since_rise = 0;
    bit                 armed = 1'b0;
    logic               p_in = 1'b0, p_mid = 1'b0, p_out = 1'b0;
    initial forever begin
        @(negedge clk);
        if (err_vld) begin
            vld_cnt++;
            last_err = error;
        end
        if (int'(IR_in_en) + int'(IR_mid_en) + int'(IR_out_en) > 1) onehot_viol++;
        if ((!busy || err_vld) && (IR_in_en || IR_mid_en || IR_out_en)) onehot_viol++;
        if (IR_mid_en && !p_mid && !(p_in && !IR_in_en)) handoff_viol++;
        if (IR_out_en && !p_out && !(p_mid && !IR_mid_en)) handoff_viol++;
        if (IR_in_en && !p_in) begin
            since_rise = 0;
            armed      = 1'b1;
        end else if (armed) begin
            since_rise++;
        end
        if (armed && strt_cnv) begin
            gaps.push_back(since_rise);
            armed = 1'b0;
        end
        p_in  = IR_in_en;
        p_mid = IR_mid_en;
        p_out = IR_out_en;
    end

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_vld(input int target, input string name);
        int n = 0;
        while (vld_cnt < target && n < c_BOUND) begin
            @(negedge clk);
            n++;
        end
        if (vld_cnt < target) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout, err_vld count %0d, expected %0d", name, vld_cnt, target);
        end
    endtask

    task automatic load(input vec_t v);
        res_tab[1] = v.r_in;
        res_tab[0] = v.l_in;
        res_tab[4] = v.r_mid;
        res_tab[2] = v.l_mid;
        res_tab[3] = v.r_out;
        res_tab[7] = v.l_out;
        res_tab[5] = 12'h000;
        res_tab[6] = 12'h000;
    endtask

    function automatic logic [31:0] idle_word();
        return {26'd0, busy, IR_in_en, IR_mid_en, IR_out_en, strt_cnv, err_vld};
    endfunction

    vec_t vecs [6];
    initial begin
        int          base_v;
        int          base_c;
        int          bad_gaps;
        int          n;
        logic [17:0] order;

        vecs[0] = '{12'h800, 12'h800, 12'h800, 12'h800, 12'h800, 12'h800, 16'sd0};
        vecs[1] = '{12'h900, 12'h800, 12'h800, 12'h800, 12'h800, 12'h800, 16'sd256};
        vecs[2] = '{12'h800, 12'h800, 12'h800, 12'h800, 12'h000, 12'hFFF, -16'sd16380};
        vecs[3] = '{12'hFFF, 12'h000, 12'hFFF, 12'h000, 12'hFFF, 12'h000, 16'sd28665};
        vecs[4] = '{12'h000, 12'hFFF, 12'h000, 12'hFFF, 12'h000, 12'hFFF, -16'sd28665};
        vecs[5] = '{12'h010, 12'h020, 12'h123, 12'h100, 12'h400, 12'h3FF, 16'sd58};

        rst_n = 1'b0;
        en    = 1'b0;
        load(vecs[0]);
        repeat (3) @(negedge clk);
        check("reset_ctrl", idle_word(), 0);
        check("reset_bus", {13'd0, chnnl, error}, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            load(vecs[i]);
            base_v = vld_cnt;
            base_c = ch_log.size();
            en = 1'b1;
            @(negedge clk);
            en = 1'b0;
            wait_vld(base_v + 1, $sformatf("v%0d_sweep", i));
            repeat (3) @(negedge clk);
            check($sformatf("v%0d_error", i), last_err, vecs[i].exp_err);
            check($sformatf("v%0d_vld_count", i), vld_cnt - base_v, 1);
            check($sformatf("v%0d_idle", i), idle_word(), 0);
            if (i == 0) begin
                check("v0_cnv_count", ch_log.size() - base_c, 6);
                order = '0;
                for (int k = 0; k < 6; k++)
                    if (base_c + k < ch_log.size()) order = {order[14:0], ch_log[base_c + k]};
                check("v0_chnnl_order", order, {3'd1, 3'd0, 3'd4, 3'd2, 3'd3, 3'd7});
            end
        end

        // Back-to-back sweeps, then en dropped during the middle pair.
        base_v = vld_cnt;
        en = 1'b1;
        wait_vld(base_v + 2, "b2b_two_sweeps");
        n = 0;
        while (!IR_mid_en && n < c_BOUND) begin
            @(negedge clk);
            n++;
        end
        check("b2b_mid_reached", IR_mid_en, 1);
        en = 1'b0;
        wait_vld(base_v + 3, "b2b_final");
        repeat (200) @(negedge clk);
        check("b2b_vld_count", vld_cnt - base_v, 3);
        check("b2b_error", last_err, vecs[5].exp_err);
        check("b2b_idle", idle_word(), 0);

        bad_gaps = 0;
        foreach (gaps[k]) if (gaps[k] != c_SETTLE) bad_gaps++;
        check("settle_gap_count", gaps.size(), 9);
        check("settle_gap_bad", bad_gaps, 0);

        // Reset during WAIT_L of the outer pair; the pending reply arrives as a stray.
        load(vecs[3]);
        base_v = vld_cnt;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        n = 0;
        while (!(IR_out_en && strt_cnv && chnnl == 3'd7) && n < c_BOUND) begin
            @(negedge clk);
            n++;
        end
        check("rst_outer_left_reached", {IR_out_en, chnnl}, {1'b1, 3'd7});
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_ctrl", idle_word(), 0);
        check("midrst_bus", {13'd0, chnnl, error}, 0);
        repeat (40) @(negedge clk);
        check("midrst_no_vld", vld_cnt - base_v, 0);
        check("midrst_stay_idle", {idle_word(), error}, 0);

        check("onehot_viol", onehot_viol, 0);
        check("handoff_viol", handoff_viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
